// File: rtl/recip_pkg.sv
// Shared types and defaults for the iterative reciprocal arbiter.
// Holds the FSM state type, default parameters and the error result constant.
package recip_pkg;

  localparam int DEF_WL       = 24;
  localparam int DEF_ITERATION = 1;
  localparam int DEF_PASS_LAT = 2;

  // Wide enough for any WL; the top slices it down to WL bits.
  localparam logic [63:0] ERR_RESULT_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/recip_rr_arb2.sv
// Two-requester round-robin grant: on contention the requester that was not
// served last wins; a lone requester always wins.
module recip_rr_arb2
  import recip_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_id,
  output logic       grant_id,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = 1'b0;
    if (&valid) begin
      grant_id = ~last_id;
    end else begin
      grant_id = valid[1];
    end
  end

endmodule

// File: rtl/recip_iter_arbiter.sv
// Arbitrates two requesters onto a shared Newton-Raphson reciprocal datapath,
// sequencing one seed pass plus ITERATION feedback passes per operand.
module recip_iter_arbiter
  import recip_pkg::*;
#(
  parameter int WL        = DEF_WL,
  parameter int ITERATION = DEF_ITERATION,
  parameter int PASS_LAT  = DEF_PASS_LAT
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          req0_valid,
  input  logic [WL-1:0] req0_din,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [WL-1:0] req1_din,
  output logic          req1_ready,
  output logic          dp_ce,
  output logic          dp_sel,
  output logic [WL-1:0] dp_din,
  input  logic [WL-1:0] dp_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [WL-1:0] rsp_dout,
  output logic          rsp_err,
  output logic          busy
);

  localparam int PW = $clog2(ITERATION + 2);
  localparam int CW = $clog2(PASS_LAT + 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(ITERATION);
  localparam logic [CW-1:0] CYC_LAST  = CW'(PASS_LAT - 1);

  state_e        state_q, state_d;
  logic [WL-1:0] operand_q, operand_d;
  logic          id_q, id_d;
  logic          last_id_q, last_id_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [WL-1:0] dout_q, dout_d;
  logic          err_q, err_d;

  logic          grant_id;
  logic          grant_valid;
  logic [WL-1:0] grant_din;

  recip_rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_id     (last_id_q),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign grant_din = grant_id ? req1_din : req0_din;

  // Readies are gated by nRST so every output reads zero while in reset.
  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    id_d       = id_q;
    last_id_d  = last_id_q;
    pass_cnt_d = pass_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    dout_d     = dout_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    dp_ce      = 1'b0;
    dp_sel     = 1'b0;
    dp_din     = '0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_dout   = '0;
    rsp_err    = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        req0_ready = nRST & grant_valid & ~grant_id;
        req1_ready = nRST & grant_valid & grant_id;
        if (grant_valid) begin
          operand_d  = grant_din;
          id_d       = grant_id;
          last_id_d  = grant_id;
          pass_cnt_d = '0;
          cyc_cnt_d  = '0;
          // Operands below 1.0 are outside the datapath's range.
          if (!grant_din[WL-1]) begin
            dout_d  = ERR_RESULT_ALL[WL-1:0];
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        dp_ce  = 1'b1;
        dp_din = operand_q;
        dp_sel = (pass_cnt_q != '0);
        if (cyc_cnt_q == CYC_LAST) begin
          cyc_cnt_d = '0;
          if (pass_cnt_q == PASS_LAST) begin
            dout_d  = dp_result;
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            pass_cnt_d = pass_cnt_q + PW'(1);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_dout  = dout_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // last_id resets to 1 so the first contended grant goes to req0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      operand_q  <= '0;
      id_q       <= 1'b0;
      last_id_q  <= 1'b1;
      pass_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      id_q       <= id_d;
      last_id_q  <= last_id_d;
      pass_cnt_q <= pass_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_recip_iter_arbiter.sv
// Self-checking bench for recip_iter_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_recip_iter_arbiter;

  localparam int WL        = 24;
  localparam int ITERATION = 1;
  localparam int PASS_LAT  = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          req0_valid, req1_valid;
  logic [WL-1:0] req0_din, req1_din;
  logic          req0_ready, req1_ready;
  logic          dp_ce, dp_sel;
  logic [WL-1:0] dp_din;
  logic [WL-1:0] dp_result;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [WL-1:0] rsp_dout;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            edge_no = 0;
  bit            m_last;
  bit            p_valid [2];
  logic [WL-1:0] p_din   [2];

  recip_iter_arbiter #(
    .WL        (WL),
    .ITERATION (ITERATION),
    .PASS_LAT  (PASS_LAT)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req0_valid (req0_valid),
    .req0_din   (req0_din),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_din   (req1_din),
    .req1_ready (req1_ready),
    .dp_ce      (dp_ce),
    .dp_sel     (dp_sel),
    .dp_din     (dp_din),
    .dp_result  (dp_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_dout   (rsp_dout),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [WL-1:0] mk(input int n);
    logic [31:0] h;
    h = 32'(n) * 32'h9E3779B1;
    h = h ^ (h >> 13);
    return h[WL-1:0];
  endfunction

  // The datapath stand-in presents a distinct, edge-numbered value every cycle.
  initial begin
    dp_result = '0;
    forever begin
      @(posedge CLK);
      edge_no++;
      #1 dp_result = mk(edge_no);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"},  32'(busy),       0);
    check_output({tag, "_rdy0"},  32'(req0_ready), 0);
    check_output({tag, "_rdy1"},  32'(req1_ready), 0);
    check_output({tag, "_ce"},    32'(dp_ce),      0);
    check_output({tag, "_sel"},   32'(dp_sel),     0);
    check_output({tag, "_din"},   32'(dp_din),     0);
    check_output({tag, "_rv"},    32'(rsp_valid),  0);
    check_output({tag, "_rid"},   32'(rsp_id),     0);
    check_output({tag, "_rdout"}, 32'(rsp_dout),   0);
    check_output({tag, "_rerr"},  32'(rsp_err),    0);
  endtask

  task automatic apply_stimulus();
    req0_valid = p_valid[0];
    req0_din   = p_din[0];
    req1_valid = p_valid[1];
    req1_din   = p_din[1];
  endtask

  function automatic logic [WL-1:0] rand_operand();
    logic [WL-1:0] d;
    d = WL'($urandom);
    d[WL-1] = ($urandom_range(0, 3) != 0);
    return d;
  endfunction

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check_all_zero("rst");
    @(negedge CLK);
    nRST = 1'b1;
    m_last = 1'b1;
  endtask

  // One complete transaction, entered and left on a falling edge.
  task automatic run_op(input int ready_delay, input int abort_at, input bit keep_valid);
    int            gid, ta, k, exp_lat;
    logic [WL-1:0] op, exp_dout;
    bit            exp_err;

    apply_stimulus();
    #1;
    gid = (p_valid[0] && p_valid[1]) ? (m_last ? 0 : 1) : (p_valid[1] ? 1 : 0);
    check_output("grant_rdy0", 32'(req0_ready), 32'(gid == 0));
    check_output("grant_rdy1", 32'(req1_ready), 32'(gid == 1));
    op = p_din[gid];
    @(posedge CLK);
    #1;
    ta = edge_no;
    m_last = (gid == 1);
    if (!keep_valid) begin
      p_valid[gid] = 1'b0;
      apply_stimulus();
    end
    exp_err  = !op[WL-1];
    exp_lat  = exp_err ? 0 : (ITERATION + 1) * PASS_LAT;
    exp_dout = exp_err ? {WL{1'b1}} : mk(ta + exp_lat - 1);

    @(negedge CLK);
    k = edge_no - ta;
    while (rsp_valid !== 1'b1 && k < exp_lat + 8) begin
      if (k == abort_at) begin
        nRST = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge CLK);
        nRST = 1'b1;
        m_last = 1'b1;
        repeat (6) begin
          @(negedge CLK);
          check_output("abort_no_rsp", 32'(rsp_valid), 0);
        end
        return;
      end
      check_output("run_ce",   32'(dp_ce),  1);
      check_output("run_sel",  32'(dp_sel), 32'(k >= PASS_LAT));
      check_output("run_din",  32'(dp_din), 32'(op));
      check_output("run_rdy",  32'({req1_ready, req0_ready}), 0);
      check_output("run_busy", 32'(busy),   1);
      @(negedge CLK);
      k = edge_no - ta;
    end

    check_output("latency",   32'(k),        32'(exp_lat));
    check_output("done_ce",   32'(dp_ce),    0);
    check_output("done_din",  32'(dp_din),   0);
    check_output("rsp_id",    32'(rsp_id),   32'(gid));
    check_output("rsp_dout",  32'(rsp_dout), 32'(exp_dout));
    check_output("rsp_err",   32'(rsp_err),  32'(exp_err));
    check_output("done_rdy",  32'({req1_ready, req0_ready}), 0);
    check_output("done_busy", 32'(busy),     1);

    for (int i = 0; i < ready_delay; i++) begin
      @(negedge CLK);
      check_output("hold_rv",   32'(rsp_valid), 1);
      check_output("hold_id",   32'(rsp_id),    32'(gid));
      check_output("hold_dout", 32'(rsp_dout),  32'(exp_dout));
      check_output("hold_err",  32'(rsp_err),   32'(exp_err));
      check_output("hold_rdy",  32'({req1_ready, req0_ready}), 0);
    end

    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    check_output("post_rv",   32'(rsp_valid), 0);
    check_output("post_busy", 32'(busy),      0);
    @(negedge CLK);
  endtask

  initial begin
    nRST       = 1'b0;
    rsp_ready  = 1'b0;
    p_valid[0] = 1'b1;
    p_valid[1] = 1'b1;
    p_din[0]   = 24'hC00000;
    p_din[1]   = 24'hC00000;
    apply_stimulus();
    m_last = 1'b1;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;
    apply_stimulus();
    nRST = 1'b1;
    @(negedge CLK);

    // Single request on req0, then the out-of-range error path on req1.
    p_valid[0] = 1'b1;
    p_din[0]   = 24'hC00000;
    run_op(0, -1, 1'b0);
    p_valid[1] = 1'b1;
    p_din[1]   = 24'h400000;
    run_op(0, -1, 1'b0);

    // Continuous contention from reset alternates 0,1,0,1; then backpressure.
    do_reset();
    p_valid[0] = 1'b1;
    p_valid[1] = 1'b1;
    p_din[0]   = 24'hA5A5A5;
    p_din[1]   = 24'hF0F0F1;
    for (int i = 0; i < 4; i++) run_op(0, -1, 1'b1);
    run_op(10, -1, 1'b1);
    run_op(0, -1, 1'b0);
    run_op(0, -1, 1'b0);

    // Reset in the middle of RUN abandons the operation; req0 then wins.
    p_valid[1] = 1'b1;
    p_din[1]   = 24'h987654;
    run_op(0, 2, 1'b0);
    p_valid[0] = 1'b1;
    p_din[0]   = 24'hDEAD01;
    p_valid[1] = 1'b1;
    p_din[1]   = 24'hBEEF02;
    run_op(0, -1, 1'b0);
    run_op(0, -1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_valid[r] && $urandom_range(0, 1) == 1) begin
          p_valid[r] = 1'b1;
          p_din[r]   = rand_operand();
        end
      end
      if (!p_valid[0] && !p_valid[1]) begin
        p_valid[0] = 1'b1;
        p_din[0]   = rand_operand();
      end
      run_op(int'($urandom_range(0, 3)), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
